util_rom_streamer: RTL and testbench
====================================

Name: util_rom_streamer

Overview:
- Sequencer that streams a contiguous block of words out of a synchronous single-port ROM (1-cycle read latency, no enable) onto an AXI-Stream master.
- A command (start address, word count) is accepted on a valid/ready port. The block drives the ROM address and absorbs the ROM latency in a 4-entry buffer, so output back-pressure is honoured without losing words.
- Sits between a util_rom instance (parent wires rom_addr/rom_data) and consumers such as 1553 message/pattern generators.

Parameters:
- ROM_WIDTH, 32, data word width; must match the ROM.
- ROM_ADDR_BITS, 12, ROM address width; the ROM depth is 2**ROM_ADDR_BITS.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  ROM_ADDR_BITS  first word address.
- cmd_len  in  ROM_ADDR_BITS  number of words minus 1 (0 = 1 word, all-ones = whole ROM).
- rom_addr  out  ROM_ADDR_BITS  to the ROM address input (registered).
- rom_data  in  ROM_WIDTH  from the ROM; valid the cycle after rom_addr is presented.
- m_axis_tdata  out  ROM_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  high with the final word of a command.
- busy  out  1  high from the cycle after command accept until the end of the transfer.
- done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset:
  - state IDLE; rom_addr=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0; busy=0, done=0.
  - Buffer and in-flight flag cleared; cmd_ready=1 the cycle after reset deasserts.
- Reset mid-transfer aborts the transfer: the buffer is flushed, tvalid drops the next cycle, and no done pulse is produced.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: rom_addr<=cmd_addr, issue_cnt<=cmd_len, out_cnt<=cmd_len; go to ISSUE.
- State ISSUE:
  - Issue rule: the word at rom_addr is issued in a cycle iff (buffer occupancy + in_flight) < 4, with occupancy sampled at the start of the cycle.
  - On issue: in_flight<=1 for the next cycle, and rom_addr increments mod 2**ROM_ADDR_BITS (0xFFF wraps to 0x000). With no issue, in_flight<=0.
  - When issue_cnt==0 and an issue occurs, go to DRAIN (rom_addr still increments); otherwise decrement issue_cnt on each issue.
- Capture: when in_flight==1, rom_data is written into the buffer at the end of that cycle.
- State DRAIN: no further issues. Leave when the final word is handshaken.
- Output side:
  - m_axis_tvalid = buffer not empty; m_axis_tdata/tlast are the buffer head.
  - tdata and tlast are held stable while tvalid&!tready.
  - tlast is set on the word written when out_cnt reaches its final value; out_cnt decrements per handshake (tvalid&tready).
- Completion: the cycle after the tlast handshake, state=IDLE, done=1 for one cycle, busy=0, cmd_ready=1. A command presented in that same cycle is accepted.
- Latency: handshake at cycle 0 → rom_addr=start at cycle 1 → rom_data valid at cycle 2 → first m_axis_tvalid at cycle 3.
- Throughput: 1 word/cycle while tready is held high. With tready low, issue stops once occupancy + in_flight reaches 4; no word is dropped or duplicated.
- Push and pop may happen in the same cycle; occupancy is then unchanged.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared constants header util_rom_streamer_defs.vh:
  - state encodings IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2.
  - BUF_DEPTH=4.
- Sub-module util_rom_streamer_fifo:
  - 4-entry synchronous FIFO, width ROM_WIDTH+1 (data plus last).
  - Outputs: count, empty, full, head.
  - Simultaneous read+write allowed when full or empty.

Test Plan:
- ROM preloaded with word[i]=i. Cmd addr=0x010, len=3, tready=1 → tdata 0x10,0x11,0x12,0x13 on consecutive cycles; first tvalid 3 cycles after accept; tlast only on 0x13; done 1 cycle after it; busy high throughout.
- Wrap: cmd addr=0xFFE, len=3 → 0xFFE,0xFFF,0x000,0x001; tlast on 0x001.
- Back-pressure: cmd addr=0, len=15, tready toggling 1-0-0-1 repeating → all 16 words exactly once, in order; data stable while stalled; occupancy never exceeds 4.
- Back-to-back: second cmd (addr=0x100, len=0) held valid → accepted in the done cycle; single word 0x100 with tlast.
- Reset mid-transfer: assert rst after 3 of 8 words → next cycle tvalid=0, busy=0, no done; cmd_ready=1 after release; a new cmd streams correctly.
- Single word: len=0 → one beat with tlast=1, then done; cmd_ready stays low while busy.

Source files
------------

// File: rtl/util_rom_streamer_pkg.sv
// Shared constants for the ROM streamer: FSM encoding and latency-buffer depth.
package util_rom_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Must cover the ROM latency plus the output register slack so that
  // 1 word/cycle is sustained and a stalled sink never loses a word.
  localparam int BUF_DEPTH = 4;

endpackage

// File: rtl/util_rom_streamer_fifo.sv
// Small synchronous FIFO holding ROM words (data plus last flag) between the
// ROM read port and the AXI-Stream output. Read and write may coincide, also
// when full or empty.
module util_rom_streamer_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [AW:0]      count_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_ok = wr_en_i && (!full_o || rd_en_i);
  assign rd_ok = rd_en_i && !empty_o;

  // Next pointer / occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer / occupancy registers; reset flushes the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/util_rom_streamer.sv
// Streams a contiguous block of ROM words onto an AXI-Stream master. The ROM
// has a fixed 1-cycle read latency and no enable, so reads are only issued
// while the buffer plus the word in flight leaves room for the returning data.
module util_rom_streamer
  import util_rom_streamer_pkg::*;
#(
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ROM_ADDR_BITS-1:0] cmd_addr,
  input  logic [ROM_ADDR_BITS-1:0] cmd_len,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data,
  output logic [ROM_WIDTH-1:0]     m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(BUF_DEPTH);

  state_e                   state_q, state_d;
  logic [ROM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [ROM_ADDR_BITS-1:0] issue_cnt_q, issue_cnt_d;
  logic                     infl_q, infl_d;
  logic                     infl_last_q, infl_last_d;
  logic                     done_q, done_d;

  logic [CW:0]              fifo_count;
  logic                     fifo_empty, fifo_full;
  logic [ROM_WIDTH:0]       fifo_head;
  logic [CW+1:0]            occ_sum;
  logic                     issue, pop;

  // Occupancy seen at the start of the cycle plus the read already in flight.
  assign occ_sum = (CW+2)'(fifo_count) + (CW+2)'(infl_q);
  assign issue   = (state_q == ST_ISSUE) && !fifo_full && (occ_sum < (CW+2)'(BUF_DEPTH));
  assign pop     = m_axis_tvalid && m_axis_tready;

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign rom_addr      = addr_q;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[ROM_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_head[ROM_WIDTH];

  // Last flag travels with the read so it lands on the final buffered word.
  util_rom_streamer_fifo #(
    .WIDTH (ROM_WIDTH + 1),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (infl_q),
    .wr_data_i ({infl_last_q, rom_data}),
    .rd_en_i   (pop),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .head_o    (fifo_head)
  );

  // Next-state: command accept, address issue and completion.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    infl_d      = issue;
    infl_last_d = issue && (issue_cnt_q == '0);
    done_d      = pop && m_axis_tlast;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          issue_cnt_d = cmd_len;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d = addr_q + ROM_ADDR_BITS'(1);
          if (issue_cnt_q == '0) state_d = ST_DRAIN;
          else                   issue_cnt_d = issue_cnt_q - ROM_ADDR_BITS'(1);
        end
      end
      ST_DRAIN: begin
        if (pop && m_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_util_rom_streamer.sv
// Directed bench for util_rom_streamer against a word[i]=i ROM model.
module tb_util_rom_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_addr;
  logic [11:0] cmd_len;
  logic [11:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM model: synchronous, 1-cycle latency, word[i] = i.
  always_ff @(posedge clk) rom_data <= {20'd0, rom_addr};

  util_rom_streamer #(.ROM_WIDTH(32), .ROM_ADDR_BITS(12)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one command from the current negedge; ends on the done cycle.
  // pat: 0 = tready always 1, 1 = tready 1-0-0-1 repeating.
  // abort: if >0, assert reset once that many words have been taken.
  // nv/na/nl: command presented on the final handshake (back-to-back).
  task automatic run_cmd(input logic [11:0] a, input logic [11:0] l, input int pat,
                         input int abort, input logic nv, input logic [11:0] na,
                         input logic [11:0] nl);
    int k = 0;
    int cyc;
    int first = -1;
    bit fin = 0;
    bit stall = 0;
    logic [31:0] held = '0;
    logic [11:0] ea;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 12'hABC; cmd_len = 12'h5A5;
    cyc = 1;
    chk("rom_addr_start", rom_addr, a);
    while (!fin && cyc < 400) begin
      if (abort > 0 && k == abort) begin
        rst = 1'b1; m_axis_tready = 1'b1;
        @(negedge clk);
        chk("abort_tvalid", m_axis_tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_no_done", done, 0);
        chk("abort_tvalid2", m_axis_tvalid, 0);
        return;
      end
      chk("busy_high", busy, 1);
      chk("cmd_ready_low", cmd_ready, 0);
      chk("done_early", done, 0);
      if (stall) chk("tdata_stable", m_axis_tdata, held);
      m_axis_tready = (pat == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      if (m_axis_tvalid && first < 0) begin
        first = cyc;
        chk("first_tvalid_lat", cyc, 3);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        ea = a + k[11:0];
        chk("tdata", m_axis_tdata, {20'd0, ea});
        chk("tlast", m_axis_tlast, (k == int'(l)) ? 1 : 0);
        if (k == int'(l)) begin
          fin = 1;
          cmd_valid = nv; cmd_addr = na; cmd_len = nl;
        end
        k++;
        stall = 0;
      end else begin
        stall = m_axis_tvalid;
        held  = m_axis_tdata;
      end
      @(negedge clk);
      cyc++;
    end
    if (!fin) chk("timeout", 0, 1);
    chk("word_count", k, int'(l) + 1);
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("cmd_ready_end", cmd_ready, 1);
    chk("tvalid_end", m_axis_tvalid, 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Basic 4-word stream.
    run_cmd(12'h010, 12'd3, 0, 0, 1'b0, '0, '0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    // Address wrap.
    run_cmd(12'hFFE, 12'd3, 0, 0, 1'b0, '0, '0);
    @(negedge clk);
    // Back-pressure, 16 words.
    run_cmd(12'h000, 12'd15, 1, 0, 1'b0, '0, '0);
    @(negedge clk);
    // Back-to-back: second command accepted in the done cycle.
    run_cmd(12'h020, 12'd2, 0, 0, 1'b1, 12'h100, 12'd0);
    run_cmd(12'h100, 12'd0, 0, 0, 1'b0, '0, '0);
    @(negedge clk);
    // Reset mid-transfer, then a fresh command.
    run_cmd(12'h200, 12'd7, 0, 3, 1'b0, '0, '0);
    run_cmd(12'h040, 12'd2, 0, 0, 1'b0, '0, '0);
    @(negedge clk);
    // Single word.
    run_cmd(12'h7A5, 12'd0, 0, 0, 1'b0, '0, '0);
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
